recompute_fault_scheduler: RTL and testbench

Sequencer for the recompute-unit (RU) bypass path of the systolic array. After built-in self-test produces the per-PE pass/fail matrix, this block scans the matrix one PE per cycle and assigns up to NUM_RU faulty PEs to recompute slots. It then drives a shared data-column sweep (0..COLS-1) through a valid/ready handshake so the RUs recompute each faulty PE's contribution. It reports the fault count and overflow, where overflow means more faults than RUs.

---
 rtl/recompute_pkg.sv | 29 ++
 rtl/recompute_fault_table.sv | 86 ++++++++
 rtl/recompute_fault_scheduler.sv | 135 +++++++++++++
 tb/tb_recompute_fault_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/recompute_pkg.sv
// Purpose: shared types and helpers for the recompute-unit bypass sequencer and RU-side blocks.
// Latency: none (types, constants and constant functions only).
// Backpressure: not applicable.
package recompute_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SCAN      = 2'd1,
    ST_RECOMPUTE = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  // Index width that never collapses to zero bits for a single-entry dimension
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Fixed-width slot record for RU-side consumers; wide enough for any practical array
  localparam int SLOT_ROW_W = 8;
  localparam int SLOT_COL_W = 8;

  typedef struct packed {
    logic                  active;
    logic [SLOT_ROW_W-1:0] row;
    logic [SLOT_COL_W-1:0] col;
  } slot_t;

endpackage

// File: rtl/recompute_fault_table.sv
// Purpose: NUM_RU-entry slot table; faults fill slots in arrival order, extra faults raise overflow.
// Latency: a write is visible on the outputs the cycle after wr_en.
// Backpressure: none; writes beyond the last slot are dropped and only set overflow.
// Ports: clk/rst (sync, active-high); clr wipes all slots; wr_en/wr_row/wr_col report one fault;
//        overflow, rc_active, rc_row, rc_col (slot s at [s*W +: W]) are registered outputs.
module recompute_fault_table
  import recompute_pkg::*;
#(
  parameter int NUM_RU = 4,
  parameter int ROW_W  = 2,
  parameter int COL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic [ROW_W-1:0]        wr_row,
  input  logic [COL_W-1:0]        wr_col,
  output logic                    overflow,
  output logic [NUM_RU-1:0]       rc_active,
  output logic [NUM_RU*ROW_W-1:0] rc_row,
  output logic [NUM_RU*COL_W-1:0] rc_col
);

  localparam int PTR_W = $clog2(NUM_RU + 1);

  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    ovf_q, ovf_d;
  logic [NUM_RU-1:0]       active_q, active_d;
  logic [NUM_RU*ROW_W-1:0] row_q, row_d;
  logic [NUM_RU*COL_W-1:0] col_q, col_d;
  logic                    full;

  assign full = (ptr_q == PTR_W'(NUM_RU));

  always_comb begin
    ptr_d    = ptr_q;
    ovf_d    = ovf_q;
    active_d = active_q;
    row_d    = row_q;
    col_d    = col_q;
    if (clr) begin
      ptr_d    = '0;
      ovf_d    = 1'b0;
      active_d = '0;
      row_d    = '0;
      col_d    = '0;
    end else if (wr_en) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        // Decode the pointer per slot so the pointer's spare top bit never indexes past the table
        for (int s = 0; s < NUM_RU; s++) begin
          if (ptr_q == PTR_W'(s)) begin
            active_d[s]                = 1'b1;
            row_d[s*ROW_W +: ROW_W]    = wr_row;
            col_d[s*COL_W +: COL_W]    = wr_col;
          end
        end
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      ovf_q    <= 1'b0;
      active_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      ovf_q    <= ovf_d;
      active_q <= active_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

  assign overflow  = ovf_q;
  assign rc_active = active_q;
  assign rc_row    = row_q;
  assign rc_col    = col_q;

endmodule

// File: rtl/recompute_fault_scheduler.sv
// Purpose: scans the self-test pass matrix one PE per cycle, assigns faulty PEs to RU slots, then sweeps data columns.
// Latency: scan takes ROWS*COLS cycles after scan_start; sweep takes COLS handshakes; done pulses one cycle later.
// Backpressure: rc_valid/rc_k hold until rc_ready; the sweep only advances on rc_valid && rc_ready.
// Ports: clk/rst (sync, active-high); scan_start, stw_pass (bit r*COLS+c, 1 = healthy), rc_ready in;
//        rc_valid, rc_k, rc_active, rc_row, rc_col, fault_count, overflow, busy, done out.
module recompute_fault_scheduler
  import recompute_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int NUM_RU = 4,
  localparam int ROW_W = width_of(ROWS),
  localparam int COL_W = width_of(COLS),
  localparam int CNT_W = $clog2(ROWS*COLS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_start,
  input  logic [ROWS*COLS-1:0]    stw_pass,
  input  logic                    rc_ready,
  output logic                    rc_valid,
  output logic [COL_W-1:0]        rc_k,
  output logic [NUM_RU-1:0]       rc_active,
  output logic [NUM_RU*ROW_W-1:0] rc_row,
  output logic [NUM_RU*COL_W-1:0] rc_col,
  output logic [CNT_W-1:0]        fault_count,
  output logic                    overflow,
  output logic                    busy,
  output logic                    done
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = width_of(N);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [COL_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              tbl_clr;
  logic              tbl_wr;
  logic              pe_fault;
  logic [ROW_W-1:0]  scan_row;
  logic [COL_W-1:0]  scan_col;

  assign pe_fault = ~stw_pass[idx_q];
  assign scan_row = ROW_W'(int'(idx_q) / COLS);
  assign scan_col = COL_W'(int'(idx_q) % COLS);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    tbl_clr = 1'b0;
    tbl_wr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // rc_ready is irrelevant here; the sweep counter is already 0 on entry
        if (scan_start) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          cnt_d   = '0;
          tbl_clr = 1'b1;
        end
      end
      ST_SCAN: begin
        if (pe_fault) begin
          cnt_d  = cnt_q + 1'b1;
          tbl_wr = 1'b1;
        end
        if (idx_q == IDX_W'(N-1)) begin
          idx_d = '0;
          // Include a fault on the final PE, which lands in the table on this same edge
          if ((|rc_active) || pe_fault) state_d = ST_RECOMPUTE;
          else                          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_RECOMPUTE: begin
        if (rc_ready) begin
          if (k_q == COL_W'(COLS-1)) begin
            k_d     = '0;
            state_d = ST_DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  recompute_fault_table #(
    .NUM_RU (NUM_RU),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .clr       (tbl_clr),
    .wr_en     (tbl_wr),
    .wr_row    (scan_row),
    .wr_col    (scan_col),
    .overflow  (overflow),
    .rc_active (rc_active),
    .rc_row    (rc_row),
    .rc_col    (rc_col)
  );

  assign rc_valid    = (state_q == ST_RECOMPUTE);
  assign rc_k        = k_q;
  assign fault_count = cnt_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_recompute_fault_scheduler.sv
module tb_recompute_fault_scheduler;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int NUM_RU = 4;
  localparam int N      = ROWS * COLS;

  logic         clk = 1'b0;
  logic         rst;
  logic         scan_start;
  logic [N-1:0] stw_pass;
  logic         rc_ready;
  logic         rc_valid;
  logic [1:0]   rc_k;
  logic [3:0]   rc_active;
  logic [7:0]   rc_row;
  logic [7:0]   rc_col;
  logic [4:0]   fault_count;
  logic         overflow;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  recompute_fault_scheduler #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .NUM_RU (NUM_RU)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_start  (scan_start),
    .stw_pass    (stw_pass),
    .rc_ready    (rc_ready),
    .rc_valid    (rc_valid),
    .rc_k        (rc_k),
    .rc_active   (rc_active),
    .rc_row      (rc_row),
    .rc_col      (rc_col),
    .fault_count (fault_count),
    .overflow    (overflow),
    .busy        (busy),
    .done        (done)
  );

  // Runs one full scan from IDLE and checks every cycle against a fault-list model.
  // ready_mode: 0 = rc_ready always 1, 1 = random, 2 = pattern 1,0,0,1,1,1.
  // pulse_at: cycle (1 = first SCAN cycle) at which an extra scan_start is pulsed, 0 = none.
  task automatic run_scan(input logic [N-1:0] pass, input int ready_mode, input int pulse_at,
                          input string name);
    int         fr[$];
    int         fc[$];
    int         pat[6] = '{1, 0, 0, 1, 1, 1};
    int         nf, hs, n, pi, seen;
    bit         fin;
    logic       rdy;
    logic [3:0] exp_act;
    logic [7:0] exp_row, exp_col;
    logic [4:0] exp_cnt;
    logic       exp_ovf;

    for (int i = 0; i < N; i++) begin
      if (!pass[i]) begin
        fr.push_back(i / COLS);
        fc.push_back(i % COLS);
      end
    end
    nf      = fr.size();
    exp_act = '0;
    exp_row = '0;
    exp_col = '0;
    for (int s = 0; s < NUM_RU && s < nf; s++) begin
      exp_act[s]         = 1'b1;
      exp_row[s*2 +: 2]  = 2'(fr[s]);
      exp_col[s*2 +: 2]  = 2'(fc[s]);
    end
    exp_ovf = (nf > NUM_RU);

    stw_pass   = pass;
    scan_start = 1'b1;
    rc_ready   = 1'b1;
    @(negedge clk);
    n   = 1;
    hs  = 0;
    pi  = 0;
    fin = 1'b0;
    while (!fin && n < 200) begin
      scan_start = (n == pulse_at);
      if (n <= N) begin
        seen = 0;
        for (int i = 0; i < n - 1; i++) if (!pass[i]) seen++;
        exp_cnt = 5'(seen);
        checks++;
        if ({busy, rc_valid, done, fault_count} !== {1'b1, 1'b0, 1'b0, exp_cnt}) begin
          failures++;
          $display("FAIL %s scan cycle %0d busy/valid/done/count: got %b expected %b", name, n,
                   {busy, rc_valid, done, fault_count}, {1'b1, 1'b0, 1'b0, exp_cnt});
        end
        rc_ready = 1'($urandom_range(0, 1));
      end else if (nf > 0 && hs < COLS) begin
        checks++;
        if ({rc_valid, done, rc_k} !== {1'b1, 1'b0, 2'(hs)}) begin
          failures++;
          $display("FAIL %s sweep cycle %0d valid/done/k: got %b expected %b", name, n,
                   {rc_valid, done, rc_k}, {1'b1, 1'b0, 2'(hs)});
        end
        case (ready_mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = (pi < 6) ? (pat[pi] != 0) : 1'b1;
        endcase
        pi++;
        rc_ready = rdy;
        if (rdy) hs++;
      end else begin
        checks++;
        if ({busy, rc_valid, done} !== 3'b101) begin
          failures++;
          $display("FAIL %s done cycle %0d busy/valid/done: got %b expected 101", name, n,
                   {busy, rc_valid, done});
        end
        fin      = 1'b1;
        rc_ready = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    scan_start = 1'b0;
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: sequence did not reach done within 200 cycles", name);
    end
    checks++;
    if ({busy, done, overflow, fault_count} !== {1'b0, 1'b0, exp_ovf, 5'(nf)}) begin
      failures++;
      $display("FAIL %s final busy/done/overflow/count: got %b expected %b", name,
               {busy, done, overflow, fault_count}, {1'b0, 1'b0, exp_ovf, 5'(nf)});
    end
    checks++;
    if ({rc_active, rc_row, rc_col} !== {exp_act, exp_row, exp_col}) begin
      failures++;
      $display("FAIL %s slots active/row/col: got %b/%h/%h expected %b/%h/%h", name,
               rc_active, rc_row, rc_col, exp_act, exp_row, exp_col);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    scan_start = 1'b0;
    rc_ready   = 1'b0;
    stw_pass   = '1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rc_valid, rc_k, rc_active, rc_row, rc_col, fault_count, overflow, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_state: got %b expected all zero",
               {rc_valid, rc_k, rc_active, rc_row, rc_col, fault_count, overflow, busy, done});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_pass();
    run_scan(16'hFFFF, 0, 0, "all_pass");
  endtask

  task automatic test_two_faults();
    run_scan(16'hEFBF, 0, 0, "two_faults");
  endtask

  task automatic test_overflow();
    run_scan(16'h7FD0, 0, 0, "six_faults");
    run_scan(16'h0000, 1, 0, "all_faulty");
  endtask

  task automatic test_backpressure();
    run_scan(16'hFDFF, 2, 0, "backpressure");
  endtask

  task automatic test_start_while_busy();
    run_scan(16'hEFBF, 0, 5, "start_in_scan");
    run_scan(16'hEFBF, 0, N + 2, "start_in_sweep");
  endtask

  task automatic test_reset_mid_scan();
    stw_pass   = 16'h7BDE;
    scan_start = 1'b1;
    rc_ready   = 1'b0;
    @(negedge clk);
    scan_start = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_scan_busy: got %b expected 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rc_valid, rc_k, rc_active, rc_row, rc_col, fault_count, overflow, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_mid_scan: got %b expected all zero",
               {rc_valid, rc_k, rc_active, rc_row, rc_col, fault_count, overflow, busy, done});
    end
    rst = 1'b0;
    run_scan(16'h7BDE, 0, 0, "after_scan_reset");
  endtask

  task automatic test_reset_mid_sweep();
    bit found = 1'b0;
    stw_pass   = 16'hFF7E;
    scan_start = 1'b1;
    rc_ready   = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (rc_valid && rc_k == 2'd2) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL sweep_reach_k2: got no rc_k=2 expected one within 40 cycles");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rc_valid, rc_k, rc_active, rc_row, rc_col, fault_count, overflow, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_mid_sweep: got %b expected all zero",
               {rc_valid, rc_k, rc_active, rc_row, rc_col, fault_count, overflow, busy, done});
    end
    rst      = 1'b0;
    rc_ready = 1'b0;
    run_scan(16'hFF7E, 1, 0, "after_sweep_reset");
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    for (int it = 0; it < 10; it++) begin
      if (it < 7) mask = 16'($urandom & $urandom & $urandom);
      else        mask = 16'($urandom);
      run_scan(~mask, 1, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_two_faults();
    test_overflow();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_scan();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
